data_sram_responder: RTL and testbench

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

---
 rtl/data_sram_pkg.sv | 27 ++
 rtl/data_sram_responder_resp_fifo.sv | 65 ++++++
 rtl/data_sram_responder.sv | 83 ++++++++
 tb/tb_data_sram_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/data_sram_pkg.sv
// Shared constants and the response-queue entry type for the data SRAM responder.
package data_sram_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam int LAT_MIN   = 1;
   localparam int LAT_MAX   = 7;
   localparam int DEPTH_MIN = 1;
   localparam int DEPTH_MAX = 4;

   // Countdown holds LAT-1 (max 6); count holds 0..DEPTH_MAX.
   localparam int CD_W  = 3;
   localparam int CNT_W = 3;

   typedef struct packed {
      logic            wr;
      logic [31:0]     data;
      logic [CD_W-1:0] cd;
   } resp_entry_t;

   function automatic logic [CD_W-1:0] init_countdown(input int lat);
      return CD_W'(lat - 1);
   endfunction

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response queue; every live countdown ticks each cycle, head pops at zero.
import data_sram_pkg::*;

module resp_fifo #(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              push,
   input  resp_entry_t       push_entry,
   input  logic              pop,
   output logic [CNT_W-1:0]  count,
   output resp_entry_t       head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;
   resp_entry_t      ent_q [DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push_ok = push & (count_q < CNT_W'(DEPTH));
   assign pop_ok  = pop & (count_q != '0);

   always_comb begin
      wptr_d  = push_ok ? ptr_inc(wptr_q) : wptr_q;
      rptr_d  = pop_ok  ? ptr_inc(rptr_q) : rptr_q;
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Entry payloads carry no reset: stale slots are never observed while count is zero.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].cd != '0) ent_q[i].cd <= ent_q[i].cd - 1'b1;
      end
      if (push_ok) ent_q[wptr_q] <= push_entry;
   end

   assign count = count_q;
   assign head  = ent_q[rptr_q];

endmodule

// File: rtl/data_sram_responder.sv
// Word-wide SRAM slave with fixed-latency, in-order responses and byte-lane writes.
import data_sram_pkg::*;

module data_sram_responder #(
   parameter int ADDR_W = 10,
   parameter int LAT    = 2,
   parameter int DEPTH  = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        addr_stall,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int LAT_C   = (LAT < LAT_MIN) ? LAT_MIN : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
   localparam int DEPTH_C = (DEPTH < DEPTH_MIN) ? DEPTH_MIN :
                            ((DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH);
   localparam int WORDS   = 1 << ADDR_W;

   logic [31:0]       mem_q [WORDS];
   logic [ADDR_W-1:0] widx;
   logic [CNT_W-1:0]  count;
   logic              accept;
   resp_entry_t       push_entry;
   resp_entry_t       head;
   logic              unused_bits;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
      logic [31:0] m;
      m = old_w;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
      end
      return m;
   endfunction

   // Upper address bits wrap silently; lane selection is the initiator's job.
   assign widx = addr[ADDR_W+1:2];

   assign unused_bits = ^{size, size == SIZE_B, size == SIZE_H, size == SIZE_W,
                          addr[31:ADDR_W+2], addr[1:0]};

   // A same-cycle pop never frees a slot for this cycle's request.
   assign addr_ok = resetn & req & ~addr_stall & (count < CNT_W'(DEPTH_C));
   assign accept  = addr_ok;

   always_comb begin
      push_entry      = '0;
      push_entry.wr   = wr;
      push_entry.data = wr ? 32'h0 : mem_q[widx];
      push_entry.cd   = init_countdown(LAT_C);
   end

   always_ff @(posedge clk) begin
      if (accept && wr) mem_q[widx] <= merge_lanes(mem_q[widx], wdata, wstrb);
   end

   resp_fifo #(
      .DEPTH (DEPTH_C)
   ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push       (accept),
      .push_entry (push_entry),
      .pop        (data_ok),
      .count      (count),
      .head       (head)
   );

   assign data_ok = (count != '0) && (head.cd == '0);
   assign rdata   = (data_ok && !head.wr) ? head.data : 32'h0;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed and randomized bench for data_sram_responder against a queue-based timing model.
module tb_data_sram_responder;

   localparam int ADDR_W = 10;
   localparam int LAT    = 2;
   localparam int DEPTH  = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = 2'd0;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        addr_stall = 1'b0;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit rstn_drv = 1'b0;

   typedef struct {
      int          due;
      bit          rd;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl [1024];

   data_sram_responder #(
      .ADDR_W (ADDR_W),
      .LAT    (LAT),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req        (req),
      .wr         (wr),
      .size       (size),
      .wstrb      (wstrb),
      .addr       (addr),
      .wdata      (wdata),
      .addr_stall (addr_stall),
      .addr_ok    (addr_ok),
      .data_ok    (data_ok),
      .rdata      (rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive at negedge, sample just after, then advance the model.
   task automatic step(input bit r, input bit w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d, input bit st,
                       output bit acc);
      bit          e_aok;
      bit          e_dok;
      logic [31:0] e_rd;
      int          wi;
      @(negedge clk);
      resetn = rstn_drv; req = r; wr = w; wstrb = s; addr = a; wdata = d;
      addr_stall = st; size = 2'($urandom_range(0, 3));
      #1;
      if (!resetn) begin
         q.delete();
         e_aok = 1'b0; e_dok = 1'b0; e_rd = 32'h0;
      end else begin
         e_aok = r && !st && (q.size() < DEPTH);
         e_dok = (q.size() > 0) && (q[0].due == cyc);
         e_rd  = (e_dok && q[0].rd) ? q[0].data : 32'h0;
      end
      check("addr_ok", {31'b0, addr_ok}, {31'b0, e_aok});
      check("data_ok", {31'b0, data_ok}, {31'b0, e_dok});
      check("rdata",   rdata, e_rd);
      if (e_dok) void'(q.pop_front());
      if (e_aok) begin
         wi = int'((a >> 2) % 1024);
         if (w) begin
            for (int b = 0; b < 4; b++) if (s[b]) mdl[wi][8*b +: 8] = d[8*b +: 8];
         end
         q.push_back('{due: cyc + LAT, rd: !w, data: (w ? 32'h0 : mdl[wi])});
      end
      acc = e_aok;
      cyc++;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acc);
   endtask

   // Hold a request until accepted, bounded so a dead DUT cannot hang the run.
   task automatic xfer(input bit w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d);
      bit acc;
      int tries;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         step(1'b1, w, s, a, d, 1'b0, acc);
         tries++;
      end
      check("xfer_accepted", {31'b0, acc}, 32'h1);
   endtask

   initial begin
      bit          acc;
      logic [31:0] rnd;
      logic [3:0]  idx;

      rstn_drv = 1'b0;
      step(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, acc);
      step(1'b1, 1'b1, 4'hF, 32'h10, 32'h0, 1'b0, acc);

      rstn_drv = 1'b1;
      for (int i = 0; i < 16; i++) xfer(1'b1, 4'hF, 32'(i * 4), 32'h0);
      idle(4);

      xfer(1'b1, 4'hF, 32'h10, 32'h11223344);
      idle(3);
      xfer(1'b0, 4'h0, 32'h10, 32'hDEADBEEF);
      idle(3);

      xfer(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
      idle(3);
      xfer(1'b0, 4'h0, 32'h20, 32'h0);
      idle(3);

      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, 32'h10 + 32'(i * 4), 32'h0, 1'b0, acc);
      idle(4);

      xfer(1'b1, 4'hF, 32'h1004, 32'hCAFE0001);
      idle(2);
      xfer(1'b0, 4'h0, 32'h0004, 32'h0);
      idle(3);

      xfer(1'b1, 4'hF, 32'h30, 32'h5A5AA5A5);
      idle(3);
      step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, acc);
      step(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, acc);
      rstn_drv = 1'b0;
      step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, acc);
      step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, acc);
      rstn_drv = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0, acc);
      idle(4);

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b1, acc);
      step(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, acc);
      check("stall_release_accept", {31'b0, addr_ok}, 32'h1);
      idle(4);

      for (int i = 0; i < 400; i++) begin
         rnd = $urandom();
         idx = 4'($urandom_range(0, 15));
         step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              {rnd[31:12], 6'b0, idx, rnd[1:0]}, $urandom(),
              $urandom_range(0, 9) < 2, acc);
      end
      idle(8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
